// File: rtl/cbus_uart_bridge.sv
// rtl/cbus_uart_bridge.sv - cbus decoder: console UART window answered locally, everything else passed to RAM
// Build option: CBUS_UART_RX_FIFO_EN adds an RXQ_DEPTH-entry receive queue behind the DATA register.
module cbus_uart_bridge #(
    parameter logic [31:0] UART_BASE = 32'h1FE0_01E0,
    parameter int unsigned UART_SIZE = 8,
    parameter int unsigned UART_LAT  = 2,
    parameter int unsigned RXQ_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        up_req_valid,
    input  logic        up_req_is_write,
    input  logic [2:0]  up_req_size,
    input  logic [31:0] up_req_addr,
    input  logic [7:0]  up_req_strobe,
    input  logic [63:0] up_req_data,
    input  logic [3:0]  up_req_len,
    input  logic [1:0]  up_req_burst,
    output logic        up_resp_ready,
    output logic        up_resp_last,
    output logic [63:0] up_resp_data,
    output logic        dn_req_valid,
    output logic        dn_req_is_write,
    output logic [2:0]  dn_req_size,
    output logic [31:0] dn_req_addr,
    output logic [7:0]  dn_req_strobe,
    output logic [63:0] dn_req_data,
    output logic [3:0]  dn_req_len,
    output logic [1:0]  dn_req_burst,
    input  logic        dn_resp_ready,
    input  logic        dn_resp_last,
    input  logic [63:0] dn_resp_data,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_ch,
    input  logic        uart_in_valid,
    input  logic [7:0]  uart_in_ch
);
    typedef enum logic [1:0] {S_IDLE, S_RAM, S_UWAIT, S_URESP} state_t;
    localparam logic [7:0] LAT_INIT = 8'(UART_LAT - 1);

    state_t      state;
    logic [7:0]  lat_cnt;
    logic [3:0]  beat;

    logic [31:0] offset;
    logic        hit;
    logic        sel_data;
    logic        sel_status;
    logic        lane_strobe;
    logic        data_read_beat0;
    logic [7:0]  wr_byte;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [31:0] rd_word;
    logic [63:0] rd_lanes;

    assign offset          = up_req_addr - UART_BASE;
    assign hit             = (up_req_addr >= UART_BASE) &&
                             ({1'b0, up_req_addr} < ({1'b0, UART_BASE} + 33'(UART_SIZE)));
    assign sel_data        = offset == 32'd0;
    assign sel_status      = offset == 32'd4;
    assign lane_strobe     = up_req_strobe[up_req_addr[2:0]];
    assign wr_byte         = up_req_data[{up_req_addr[2:0], 3'b000} +: 8];
    assign data_read_beat0 = (state == S_URESP) && (beat == 4'd0) && !up_req_is_write && sel_data;

`ifdef CBUS_UART_RX_FIFO_EN
    localparam int unsigned PW = $clog2(RXQ_DEPTH);

    logic [7:0]  rxq [RXQ_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        rxq_empty;
    logic        rxq_full;
    logic        rxq_push;
    logic        rxq_pop;

    assign rxq_empty = wr_ptr == rd_ptr;
    assign rxq_full  = (wr_ptr - rd_ptr) == (PW + 1)'(RXQ_DEPTH);
    assign rxq_pop   = data_read_beat0 && !rxq_empty;
    // A full queue still accepts a char in the cycle its head is being popped.
    assign rxq_push  = uart_in_valid && (!rxq_full || rxq_pop);
    assign rx_valid  = !rxq_empty;
    assign rx_byte   = rxq_empty ? 8'h00 : rxq[rd_ptr[PW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rxq_push) begin
                rxq[wr_ptr[PW-1:0]] <= uart_in_ch;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rxq_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
`else
    assign rx_valid = uart_in_valid;
    assign rx_byte  = uart_in_valid ? uart_in_ch : 8'h00;
`endif

    assign rd_word  = sel_data   ? {24'h0, rx_byte} :
                      sel_status ? {30'h0, 1'b1, rx_valid} : 32'h0;
    assign rd_lanes = {32'h0, rd_word} << {up_req_addr[2:0], 3'b000};

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            lat_cnt        <= 8'h00;
            beat           <= 4'h0;
            uart_out_valid <= 1'b0;
            uart_out_ch    <= 8'h00;
        end else begin
            uart_out_valid <= 1'b0;
            uart_out_ch    <= 8'h00;
            case (state)
                S_IDLE: begin
                    if (up_req_valid) begin
                        if (hit) begin
                            state   <= S_UWAIT;
                            lat_cnt <= LAT_INIT;
                        end else begin
                            state <= S_RAM;
                        end
                    end
                end
                S_RAM: begin
                    if (dn_resp_ready && dn_resp_last) begin
                        state <= S_IDLE;
                    end
                end
                S_UWAIT: begin
                    if (lat_cnt == 8'h00) begin
                        state <= S_URESP;
                        beat  <= 4'h0;
                        // Pulse lines up with the beat-0 response cycle.
                        if (up_req_is_write && sel_data && lane_strobe) begin
                            uart_out_valid <= 1'b1;
                            uart_out_ch    <= wr_byte;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 8'h01;
                    end
                end
                S_URESP: begin
                    if (beat == up_req_len) begin
                        state <= S_IDLE;
                    end else begin
                        beat <= beat + 4'h1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        dn_req_valid    = 1'b0;
        dn_req_is_write = 1'b0;
        dn_req_size     = 3'h0;
        dn_req_addr     = 32'h0;
        dn_req_strobe   = 8'h0;
        dn_req_data     = 64'h0;
        dn_req_len      = 4'h0;
        dn_req_burst    = 2'h0;
        up_resp_ready   = 1'b0;
        up_resp_last    = 1'b0;
        up_resp_data    = 64'h0;
        case (state)
            S_RAM: begin
                dn_req_valid    = up_req_valid;
                dn_req_is_write = up_req_is_write;
                dn_req_size     = up_req_size;
                dn_req_addr     = up_req_addr;
                dn_req_strobe   = up_req_strobe;
                dn_req_data     = up_req_data;
                dn_req_len      = up_req_len;
                dn_req_burst    = up_req_burst;
                up_resp_ready   = dn_resp_ready;
                up_resp_last    = dn_resp_last;
                up_resp_data    = dn_resp_data;
            end
            S_URESP: begin
                up_resp_ready = 1'b1;
                up_resp_last  = beat == up_req_len;
                up_resp_data  = (beat == 4'h0 && !up_req_is_write) ? rd_lanes : 64'h0;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_cbus_uart_bridge.sv
// tb/tb_cbus_uart_bridge.sv - randomized self-checking bench for cbus_uart_bridge
module tb_cbus_uart_bridge;
    localparam logic [31:0] BASE = 32'h1FE0_01E0;
    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        up_req_valid = 1'b0;
    logic        up_req_is_write = 1'b0;
    logic [2:0]  up_req_size = 3'h0;
    logic [31:0] up_req_addr = 32'h0;
    logic [7:0]  up_req_strobe = 8'h0;
    logic [63:0] up_req_data = 64'h0;
    logic [3:0]  up_req_len = 4'h0;
    logic [1:0]  up_req_burst = 2'h0;
    logic        up_resp_ready, up_resp_last;
    logic [63:0] up_resp_data;
    logic        dn_req_valid, dn_req_is_write;
    logic [2:0]  dn_req_size;
    logic [31:0] dn_req_addr;
    logic [7:0]  dn_req_strobe;
    logic [63:0] dn_req_data;
    logic [3:0]  dn_req_len;
    logic [1:0]  dn_req_burst;
    logic        dn_resp_ready = 1'b0;
    logic        dn_resp_last = 1'b0;
    logic [63:0] dn_resp_data = 64'h0;
    logic        uart_out_valid;
    logic [7:0]  uart_out_ch;
    logic        uart_in_valid = 1'b0;
    logic [7:0]  uart_in_ch = 8'h0;

    cbus_uart_bridge dut (
        .clock(clock), .reset(reset),
        .up_req_valid(up_req_valid), .up_req_is_write(up_req_is_write), .up_req_size(up_req_size),
        .up_req_addr(up_req_addr), .up_req_strobe(up_req_strobe), .up_req_data(up_req_data),
        .up_req_len(up_req_len), .up_req_burst(up_req_burst),
        .up_resp_ready(up_resp_ready), .up_resp_last(up_resp_last), .up_resp_data(up_resp_data),
        .dn_req_valid(dn_req_valid), .dn_req_is_write(dn_req_is_write), .dn_req_size(dn_req_size),
        .dn_req_addr(dn_req_addr), .dn_req_strobe(dn_req_strobe), .dn_req_data(dn_req_data),
        .dn_req_len(dn_req_len), .dn_req_burst(dn_req_burst),
        .dn_resp_ready(dn_resp_ready), .dn_resp_last(dn_resp_last), .dn_resp_data(dn_resp_data),
        .uart_out_valid(uart_out_valid), .uart_out_ch(uart_out_ch),
        .uart_in_valid(uart_in_valid), .uart_in_ch(uart_in_ch)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    int          obs_first_resp, obs_first_dn, obs_dn_cycles, obs_pulses;
    logic [7:0]  obs_pulse_ch;
    logic        obs_timeout;
    logic [63:0] obs_data[$];
    logic        obs_last[$];
    logic [63:0] ram_sent[$];
    logic [31:0] cap_addr;
    logic        cap_wr;
    logic [2:0]  cap_size;
    logic [7:0]  cap_strb;
    logic [63:0] cap_data;
    logic [3:0]  cap_len;
    logic [1:0]  cap_burst;
    logic [7:0]  rxq_m[$];

    function automatic logic [189:0] all_outputs();
        return {up_resp_ready, up_resp_last, up_resp_data, dn_req_valid, dn_req_is_write, dn_req_size,
                dn_req_addr, dn_req_strobe, dn_req_data, dn_req_len, dn_req_burst, uart_out_valid, uart_out_ch};
    endfunction

    // Register map as seen by the master: DATA at offset 0, STATUS at offset 4, rest reads 0.
    function automatic logic [63:0] exp_read(int off, logic rxv, logic [7:0] rxb);
        if (off == 0) return {56'h0, rxb};
        if (off == 4) return {24'h0, 6'h0, 1'b1, rxv, 32'h0};
        return 64'h0;
    endfunction

    // Master + RAM responder: runs one transaction from the IDLE cycle and records what was observed.
    task automatic drive_txn(input logic wr, input logic [31:0] addr, input logic [7:0] strb,
                             input logic [63:0] wdata, input logic [3:0] len, input int ready_pct);
        int   rbeat;
        logic done, acc;
        obs_first_resp = -1; obs_first_dn = -1; obs_dn_cycles = 0; obs_pulses = 0; obs_pulse_ch = 8'h0;
        obs_data.delete(); obs_last.delete(); ram_sent.delete();
        up_req_valid = 1'b1; up_req_is_write = wr; up_req_addr = addr; up_req_strobe = strb;
        up_req_data = wdata; up_req_len = len;
        up_req_size = 3'($urandom_range(3)); up_req_burst = 2'($urandom_range(3));
        rbeat = 0; done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            dn_resp_ready = 1'b0; dn_resp_last = 1'b0; dn_resp_data = 64'h0;
            if (dn_req_valid && $urandom_range(99) < ready_pct) begin
                dn_resp_ready = 1'b1; dn_resp_data = {$urandom, $urandom}; dn_resp_last = (rbeat == int'(len));
            end
            @(negedge clock);
            if (dn_req_valid) begin
                obs_dn_cycles++;
                if (obs_first_dn < 0) begin
                    obs_first_dn = cyc; cap_addr = dn_req_addr; cap_wr = dn_req_is_write; cap_size = dn_req_size;
                    cap_strb = dn_req_strobe; cap_data = dn_req_data; cap_len = dn_req_len; cap_burst = dn_req_burst;
                end
            end
            if (uart_out_valid) begin
                obs_pulses++; obs_pulse_ch = uart_out_ch;
            end
            acc = up_resp_ready;
            if (up_resp_ready) begin
                if (obs_first_resp < 0) obs_first_resp = cyc;
                obs_data.push_back(up_resp_data); obs_last.push_back(up_resp_last);
                if (up_resp_last) done = 1'b1;
            end
            if (dn_resp_ready) begin
                ram_sent.push_back(dn_resp_data); rbeat++;
            end
            @(posedge clock); #1;
            if (acc) up_req_data = {$urandom, $urandom};
        end
        obs_timeout = !done;
        up_req_valid = 1'b0; dn_resp_ready = 1'b0; dn_resp_last = 1'b0; dn_resp_data = 64'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (all_outputs() !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_outputs()); end
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        checks++; if (all_outputs() !== '0) begin failures++; $display("FAIL idle_outputs got=%h exp=0", all_outputs()); end
        @(posedge clock); #1;
    endtask

    task automatic test_ram_read();
        int bad = 0;
        drive_txn(1'b0, 32'h1C00_0000, 8'hFF, 64'h0, 4'd3, 100);
        checks++; if (obs_timeout) begin failures++; $display("FAIL ram_read_timeout got=1 exp=0"); end
        checks++; if (obs_first_dn != 1) begin failures++; $display("FAIL ram_read_dn_latency got=%0d exp=1", obs_first_dn); end
        checks++; if ({cap_wr, cap_addr, cap_size, cap_strb, cap_len, cap_burst} !== {1'b0, 32'h1C00_0000, up_req_size, 8'hFF, 4'd3, up_req_burst}) begin
            failures++; $display("FAIL ram_read_mirror got=%h/%h/%h/%h exp=0/1c000000/%h/3", cap_wr, cap_addr, cap_size, cap_len, up_req_size); end
        checks++; if (obs_data.size() != 4 || ram_sent.size() != 4) begin failures++; $display("FAIL ram_read_beats got=%0d exp=4", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < ram_sent.size(); i++)
            if (obs_data[i] !== ram_sent[i] || obs_last[i] !== (i == 3)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL ram_read_relay got=%0d_bad_beats exp=0", bad); end
        checks++; if (obs_first_resp != 1 || obs_pulses != 0) begin failures++; $display("FAIL ram_read_resp got=%0d/%0d exp=1/0", obs_first_resp, obs_pulses); end
        @(negedge clock);
        checks++; if (dn_req_valid !== 1'b0) begin failures++; $display("FAIL ram_read_idle got=%b exp=0", dn_req_valid); end
        @(posedge clock); #1;
    endtask

    task automatic test_uart_write();
        drive_txn(1'b1, BASE, 8'h01, 64'h41, 4'd0, 100);
        checks++; if (obs_first_resp != LAT + 1 || obs_data.size() != 1) begin failures++; $display("FAIL uart_wr_latency got=%0d/%0d exp=%0d/1", obs_first_resp, obs_data.size(), LAT + 1); end
        checks++; if (obs_data.size() == 1 && (obs_last[0] !== 1'b1 || obs_data[0] !== 64'h0)) begin failures++; $display("FAIL uart_wr_resp got=%b/%h exp=1/0", obs_last[0], obs_data[0]); end
        checks++; if (obs_pulses != 1 || obs_pulse_ch !== 8'h41) begin failures++; $display("FAIL uart_wr_pulse got=%0d/%h exp=1/41", obs_pulses, obs_pulse_ch); end
        checks++; if (obs_dn_cycles != 0) begin failures++; $display("FAIL uart_wr_dn got=%0d exp=0", obs_dn_cycles); end
        drive_txn(1'b1, BASE, 8'hFE, 64'h42, 4'd0, 100);
        checks++; if (obs_pulses != 0 || obs_timeout) begin failures++; $display("FAIL uart_wr_nostrobe got=%0d exp=0", obs_pulses); end
        drive_txn(1'b1, BASE + 32'd4, 8'hFF, 64'h43_0000_0043, 4'd0, 100);
        checks++; if (obs_pulses != 0 || obs_timeout) begin failures++; $display("FAIL uart_wr_status got=%0d exp=0", obs_pulses); end
    endtask

    task automatic test_status();
        uart_in_valid = 1'b0;
        drive_txn(1'b0, BASE + 32'd4, 8'h00, 64'h0, 4'd0, 100);
        checks++; if (obs_data.size() != 1 || obs_data[0] !== 64'h0000_0002_0000_0000) begin failures++; $display("FAIL status_idle got=%h exp=0000000200000000", obs_data[0]); end
`ifndef CBUS_UART_RX_FIFO_EN
        uart_in_valid = 1'b1; uart_in_ch = 8'h5A;
        drive_txn(1'b0, BASE + 32'd4, 8'h00, 64'h0, 4'd0, 100);
        checks++; if (obs_data.size() != 1 || obs_data[0] !== 64'h0000_0003_0000_0000) begin failures++; $display("FAIL status_pending got=%h exp=0000000300000000", obs_data[0]); end
        uart_in_valid = 1'b0;
`endif
    endtask

    task automatic test_rx();
        logic [7:0] exp;
`ifdef CBUS_UART_RX_FIFO_EN
        for (int i = 0; i < 5; i++) begin
            uart_in_valid = 1'b1; uart_in_ch = 8'h61 + 8'(i);
            if (rxq_m.size() < 4) rxq_m.push_back(uart_in_ch);
            @(posedge clock); #1;
        end
        uart_in_valid = 1'b0;
        drive_txn(1'b0, BASE + 32'd4, 8'h00, 64'h0, 4'd0, 100);
        checks++; if (obs_data.size() != 1 || obs_data[0] !== exp_read(4, 1'b1, 8'h0)) begin failures++; $display("FAIL fifo_status got=%h exp=%h", obs_data[0], exp_read(4, 1'b1, 8'h0)); end
        for (int i = 0; i < 5; i++) begin
            exp = (rxq_m.size() > 0) ? rxq_m.pop_front() : 8'h00;
            drive_txn(1'b0, BASE, 8'h00, 64'h0, 4'd0, 100);
            checks++; if (obs_data.size() != 1 || obs_data[0] !== {56'h0, exp}) begin failures++; $display("FAIL fifo_read%0d got=%h exp=%h", i, obs_data[0], exp); end
        end
        drive_txn(1'b0, BASE + 32'd4, 8'h00, 64'h0, 4'd0, 100);
        checks++; if (obs_data.size() != 1 || obs_data[0] !== exp_read(4, 1'b0, 8'h0)) begin failures++; $display("FAIL fifo_drained got=%h exp=%h", obs_data[0], exp_read(4, 1'b0, 8'h0)); end
`else
        uart_in_valid = 1'b1; uart_in_ch = 8'($urandom); exp = uart_in_ch;
        drive_txn(1'b0, BASE, 8'h00, 64'h0, 4'd0, 100);
        checks++; if (obs_data.size() != 1 || obs_data[0] !== {56'h0, exp}) begin failures++; $display("FAIL rx_direct got=%h exp=%h", obs_data[0], exp); end
        uart_in_valid = 1'b0;
        drive_txn(1'b0, BASE, 8'h00, 64'h0, 4'd0, 100);
        checks++; if (obs_data.size() != 1 || obs_data[0] !== 64'h0) begin failures++; $display("FAIL rx_empty got=%h exp=0", obs_data[0]); end
`endif
    endtask

    task automatic test_reset_mid();
        up_req_valid = 1'b1; up_req_is_write = 1'b0; up_req_addr = 32'h1C00_0100; up_req_len = 4'd3;
        up_req_strobe = 8'hFF; up_req_size = 3'd3; up_req_burst = 2'd1;
        @(posedge clock); #1;
        dn_resp_ready = 1'b1; dn_resp_last = 1'b0; dn_resp_data = {$urandom, $urandom};
        repeat (2) @(posedge clock);
        #1; reset = 1'b1;
        @(negedge clock);
        checks++; if (up_resp_ready !== 1'b1 || up_resp_data !== dn_resp_data) begin failures++; $display("FAIL reset_mid_beat2 got=%b/%h exp=1/%h", up_resp_ready, up_resp_data, dn_resp_data); end
        @(posedge clock); #1;
        reset = 1'b0; up_req_valid = 1'b0;
        @(negedge clock);
        checks++; if (all_outputs() !== '0) begin failures++; $display("FAIL reset_mid_outputs got=%h exp=0", all_outputs()); end
        @(posedge clock); #1;
        dn_resp_ready = 1'b0;
        drive_txn(1'b1, BASE, 8'h01, 64'h7E, 4'd0, 100);
        checks++; if (obs_timeout || obs_first_resp != LAT + 1 || obs_pulses != 1 || obs_pulse_ch !== 8'h7E) begin
            failures++; $display("FAIL reset_mid_recover got=%0d/%0d/%h exp=%0d/1/7e", obs_first_resp, obs_pulses, obs_pulse_ch, LAT + 1); end
    endtask

    task automatic test_back_to_back();
        int pulses, uart_first;
        drive_txn(1'b1, BASE, 8'h01, 64'h33, 4'd0, 100);
        pulses = obs_pulses; uart_first = obs_first_resp;
        drive_txn(1'b1, 32'h0000_1000, 8'h0F, 64'h1234_5678, 4'd1, 100);
        pulses += obs_pulses;
        checks++; if (uart_first != LAT + 1 || obs_first_dn != 1) begin failures++; $display("FAIL b2b_bubble got=%0d/%0d exp=%0d/1", uart_first, obs_first_dn, LAT + 1); end
        checks++; if (cap_data !== 64'h1234_5678 || cap_wr !== 1'b1) begin failures++; $display("FAIL b2b_wdata got=%h exp=12345678", cap_data); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [63:0] wdata, exp0;
        logic [7:0]  strb, rxb;
        logic [3:0]  len;
        logic        wr, rxv;
        int          off, bad, exp_pulses;
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom); len = 4'($urandom_range(3)); wdata = {$urandom, $urandom}; strb = 8'($urandom);
            if ($urandom_range(1) == 0) begin
                case ($urandom_range(3))
                    0: addr = BASE - 32'd1;
                    1: addr = BASE + 32'd8;
                    default: addr = $urandom;
                endcase
                if (addr >= BASE && addr < BASE + 32'd8) addr = BASE + 32'h100;
                drive_txn(wr, addr, strb, wdata, len, 60);
                bad = 0;
                for (int i = 0; i < obs_data.size() && i < ram_sent.size(); i++)
                    if (obs_data[i] !== ram_sent[i] || obs_last[i] !== (i == int'(len))) bad++;
                checks++; if (obs_timeout || obs_first_dn != 1 || obs_pulses != 0) begin failures++; $display("FAIL rnd%0d_ram_ctl got=%b/%0d/%0d exp=0/1/0", t, obs_timeout, obs_first_dn, obs_pulses); end
                checks++; if ({cap_wr, cap_addr, cap_len, cap_strb} !== {wr, addr, len, strb}) begin failures++; $display("FAIL rnd%0d_ram_mirror got=%h exp=%h", t, {cap_wr, cap_addr, cap_len, cap_strb}, {wr, addr, len, strb}); end
                checks++; if (bad != 0 || obs_data.size() != int'(len) + 1) begin failures++; $display("FAIL rnd%0d_ram_relay got=%0d/%0d exp=0/%0d", t, bad, obs_data.size(), len + 1); end
            end else begin
                off = $urandom_range(7); addr = BASE + 32'(off);
`ifdef CBUS_UART_RX_FIFO_EN
                uart_in_valid = 1'b0;
                rxv = rxq_m.size() > 0; rxb = rxv ? rxq_m[0] : 8'h00;
                if (!wr && off == 0 && rxv) void'(rxq_m.pop_front());
`else
                uart_in_valid = 1'($urandom); uart_in_ch = 8'($urandom);
                rxv = uart_in_valid; rxb = uart_in_valid ? uart_in_ch : 8'h00;
`endif
                exp0 = wr ? 64'h0 : exp_read(off, rxv, rxb);
                exp_pulses = (wr && off == 0 && strb[0]) ? 1 : 0;
                drive_txn(wr, addr, strb, wdata, len, 100);
                bad = 0;
                for (int i = 0; i < obs_data.size(); i++)
                    if (obs_data[i] !== ((i == 0) ? exp0 : 64'h0) || obs_last[i] !== (i == int'(len))) bad++;
                checks++; if (obs_timeout || obs_first_resp != LAT + 1 || obs_dn_cycles != 0) begin failures++; $display("FAIL rnd%0d_uart_ctl got=%b/%0d/%0d exp=0/%0d/0", t, obs_timeout, obs_first_resp, obs_dn_cycles, LAT + 1); end
                checks++; if (bad != 0 || obs_data.size() != int'(len) + 1) begin failures++; $display("FAIL rnd%0d_uart_data off=%0d got=%h exp=%h", t, off, obs_data[0], exp0); end
                checks++; if (obs_pulses != exp_pulses || (exp_pulses == 1 && obs_pulse_ch !== wdata[7:0])) begin
                    failures++; $display("FAIL rnd%0d_uart_pulse got=%0d/%h exp=%0d/%h", t, obs_pulses, obs_pulse_ch, exp_pulses, wdata[7:0]); end
            end
        end
        uart_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_uart_write();
        test_status();
        test_rx();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
